tpu_tile_scheduler: RTL

Sequencing controller for the TPU 4x4 systolic array: on `in_valid` it latches the GEMM dimensions K, M and N, walks all 4x4 output tiles, and drives the A/B buffer read addresses and array control for each tile. It then drains each finished tile row by row into the C buffer. It sits between the host-facing `busy`/`in_valid` handshake and the A/B/C global buffers plus the PE array, and replaces ad-hoc counter logic in the top level.

---
 rtl/tpu_pkg.sv | 23 ++
 rtl/tpu_sched_ctr.sv | 31 +++
 rtl/tpu_tile_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU tile scheduler: FSM state encoding,
// buffer/row widths and a ceil-div helper for tile counts.
package tpu_pkg;

    localparam int TILE  = 4;
    localparam int IDX_W = 16;
    localparam int ROW_W = 128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

    function automatic logic [IDX_W-1:0] ceil_div(input logic [IDX_W-1:0] num,
                                                  input logic [IDX_W-1:0] den);
        return (num + den - 16'd1) / den;
    endfunction

endpackage

// File: rtl/tpu_sched_ctr.sv
// Loadable wrapping up-counter with a terminal-count flag; used for the
// k, row, n_tile and m_tile loops of the tile scheduler.
module tpu_sched_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    // Count register: load has priority, wrap to zero after the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for the 4x4 systolic array: walks all output tiles, feeds A/B,
// drains rows into C. Optional perf counters under `TPU_SCHED_PERF_EN.
module tpu_tile_scheduler #(
    parameter int TILE      = 4,
    parameter int DRAIN_CYC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   K,
    input  logic [7:0]   M,
    input  logic [7:0]   N,
    output logic         busy,
    output logic [15:0]  A_index,
    output logic         A_wr_en,
    output logic [15:0]  B_index,
    output logic         B_wr_en,
    output logic         arr_clear,
    output logic         arr_valid,
    output logic [1:0]   arr_row_sel,
    input  logic [127:0] arr_row_data,
    output logic         C_wr_en,
    output logic [15:0]  C_index,
    output logic [127:0] C_data_in,
    output logic [31:0]  perf_cycles,
    output logic [15:0]  perf_tiles
);
    import tpu_pkg::*;

    sched_state_t     state;
    logic [IDX_W-1:0] k_dim_r, mt_r, nt_r;
    logic [7:0]       drain_cnt_r;
    logic [IDX_W-1:0] k_cnt_s, n_cnt_s, m_cnt_s;
    logic [1:0]       r_cnt_s;
    logic             k_tc_s, r_tc_s, n_tc_s, m_tc_s;
    logic             accept_s, dims_ok_s, row_last_s;
    logic [IDX_W-1:0] c_row_s, c_idx_s;

    assign accept_s   = (state == S_IDLE) && in_valid;
    assign dims_ok_s  = (K != 8'd0) && (M != 8'd0) && (N != 8'd0);
    assign row_last_s = (state == S_WRITE) && r_tc_s;
    assign c_row_s    = m_cnt_s * 16'(TILE) + {14'd0, r_cnt_s};
    assign c_idx_s    = c_row_s * nt_r + n_cnt_s;

    assign A_wr_en     = 1'b0;
    assign B_wr_en     = 1'b0;
    assign arr_row_sel = r_cnt_s;

    tpu_sched_ctr #(.W(IDX_W)) u_k_ctr (
        .clk(clk), .rst(rst), .load(state == S_CLEAR), .load_val('0),
        .en(state == S_FEED), .last(k_dim_r - 16'd1), .count(k_cnt_s), .tc(k_tc_s)
    );

    tpu_sched_ctr #(.W(2)) u_r_ctr (
        .clk(clk), .rst(rst), .load(accept_s), .load_val('0),
        .en(state == S_WRITE), .last(2'd3), .count(r_cnt_s), .tc(r_tc_s)
    );

    tpu_sched_ctr #(.W(IDX_W)) u_n_ctr (
        .clk(clk), .rst(rst), .load(accept_s), .load_val('0),
        .en(row_last_s), .last(nt_r - 16'd1), .count(n_cnt_s), .tc(n_tc_s)
    );

    tpu_sched_ctr #(.W(IDX_W)) u_m_ctr (
        .clk(clk), .rst(rst), .load(accept_s), .load_val('0),
        .en(row_last_s && n_tc_s), .last(mt_r - 16'd1), .count(m_cnt_s), .tc(m_tc_s)
    );

    // Main FSM with registered buffer/array control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            k_dim_r     <= 16'd0;
            mt_r        <= 16'd0;
            nt_r        <= 16'd0;
            drain_cnt_r <= 8'd0;
            A_index     <= 16'd0;
            B_index     <= 16'd0;
            arr_clear   <= 1'b0;
            arr_valid   <= 1'b0;
            C_wr_en     <= 1'b0;
            C_index     <= 16'd0;
            C_data_in   <= 128'd0;
        end else begin
            arr_clear <= 1'b0;
            arr_valid <= (state == S_FEED);
            // Row readout is captured one cycle after it is selected.
            C_wr_en   <= (state == S_WRITE);
            if (state == S_WRITE) begin
                C_index   <= c_idx_s;
                C_data_in <= arr_row_data;
            end else begin
                C_index   <= C_index;
                C_data_in <= C_data_in;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        busy    <= 1'b1;
                        k_dim_r <= {8'd0, K};
                        mt_r    <= ceil_div({8'd0, M}, 16'(TILE));
                        nt_r    <= ceil_div({8'd0, N}, 16'(TILE));
                        if (dims_ok_s) begin
                            state     <= S_CLEAR;
                            arr_clear <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    A_index <= m_cnt_s * k_dim_r;
                    B_index <= n_cnt_s * k_dim_r;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    if (k_tc_s) begin
                        drain_cnt_r <= 8'd0;
                        state       <= S_DRAIN;
                    end else begin
                        A_index <= A_index + 16'd1;
                        B_index <= B_index + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == 8'(DRAIN_CYC - 1)) begin
                        state <= S_WRITE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (r_tc_s && n_tc_s && m_tc_s) begin
                        state <= S_DONE;
                    end else if (r_tc_s) begin
                        state     <= S_CLEAR;
                        arr_clear <= 1'b1;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TPU_SCHED_PERF_EN
    // Busy-cycle and completed-tile counters, saturating, cleared per job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= 32'd0;
            perf_tiles  <= 16'd0;
        end else if (accept_s) begin
            perf_cycles <= 32'd0;
            perf_tiles  <= 16'd0;
        end else begin
            if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end else begin
                perf_cycles <= perf_cycles;
            end
            if (row_last_s && (perf_tiles != 16'hFFFF)) begin
                perf_tiles <= perf_tiles + 16'd1;
            end else begin
                perf_tiles <= perf_tiles;
            end
        end
    end
`else
    assign perf_cycles = 32'd0;
    assign perf_tiles  = 16'd0;
`endif

endmodule
